fir_phase_sequencer: RTL and testbench
======================================

FIR_PHASE_SEQUENCER -- requirements
Module: fir_phase_sequencer

Interface
REQ-001 Parameter NB_DATA, 8: sample width, signed, all data ports.
REQ-002 Parameter N_PHASES, 4: polyphase branches, i.e. the interpolation factor; legal values are powers of two from 2 to 16.
REQ-003 Parameter NB_PHASE, 2: width of the phase index, equal to log2(N_PHASES).
REQ-004 Port clock, input, 1: single system clock, rising edge.
REQ-005 Port i_reset, input, 1: reset, asynchronous, active-high.
REQ-006 Port i_valid, input, 1: upstream sample valid.
REQ-007 Port i_data, input, NB_DATA: upstream sample.
REQ-008 Port o_ready, output, 1: sequencer accepts the upstream sample this cycle.
REQ-009 Port o_fir_data, output, NB_DATA: held sample driven to the FIR data input.
REQ-010 Port o_phase, output, NB_PHASE: coefficient-bank select for the FIR.
REQ-011 Port o_fir_enable, output, 1: FIR shift-register enable strobe.
REQ-012 Port i_fir_data, input, NB_DATA: combinational FIR output for the current o_fir_data/o_phase.
REQ-013 Port o_data / o_valid, output, NB_DATA / 1: interpolated output sample and its valid.
REQ-014 Port i_ready, input, 1: downstream ready; an output transfers on an edge where o_valid and i_ready are both high.

Function
REQ-015 States: IDLE, RUN, HOLD; encoding is free.
REQ-016 Signal slot_free is defined as (!o_valid || i_ready).
REQ-017 o_ready shall be high in IDLE, and high in RUN only when phase == N_PHASES-1 and slot_free; it is low otherwise and low while i_reset is high.
REQ-018 Accept, defined as i_valid && o_ready: at that edge, latch i_data into o_fir_data, set phase to 0, and set state to RUN.
REQ-019 RUN with slot_free: at the edge, capture o_data <= i_fir_data, set o_valid to 1, and advance phase by 1.
REQ-020 RUN without slot_free: move to HOLD; phase, o_fir_data and o_data are frozen.
REQ-021 HOLD: move to RUN at the first edge where i_ready is high; o_valid and o_data stay stable until transferred.
REQ-022 o_fir_enable shall equal (state==RUN && phase==N_PHASES-1 && slot_free), combinational from registered state; it is high for exactly one cycle per input sample, on the last phase capture.
REQ-023 Last phase captured in RUN: if Accept is also true on the same edge, go to RUN at phase 0 with the new sample, giving back-to-back operation with no bubble; otherwise go to IDLE.
REQ-024 Phase wrap: N_PHASES-1 advances to 0 only through REQ-023, never by free-running.
REQ-025 o_valid shall clear at a transfer edge when no new capture occurs on that edge (IDLE, or HOLD exit edge).
REQ-026 Latency: Accept at edge k gives o_valid high after edge k+1, carrying the phase-0 result.
REQ-027 Throughput: one output per cycle and one input per N_PHASES cycles when i_ready is held high.
REQ-028 o_phase shall equal the internal phase register in all states.
REQ-029 No arithmetic is performed on data; o_data is a bit-exact copy of i_fir_data sampled at the capture edge.

Reset
REQ-030 Assertion of i_reset, at any time including mid-RUN or in HOLD, forces state=IDLE, phase=0, o_fir_data=0, o_data=0 and o_valid=0 immediately, without waiting for a clock edge.
REQ-031 While i_reset is high, o_fir_enable and o_ready are 0; a partially sequenced sample is discarded and the FIR is not shifted.
REQ-032 In the first cycle after reset deassertion, o_ready is 1.

Configuration
REQ-033 When macro FIR_SEQ_STALL_CNT_EN is defined, add output o_stall_count (16 bits): it increments on every clock cycle spent in HOLD, saturates at 16'hFFFF, and resets to 0 asynchronously.
REQ-034 When FIR_SEQ_STALL_CNT_EN is undefined, the port and the counter logic are absent; all other behaviour is identical.

Verification
REQ-035 Scenario 1: N_PHASES=4, i_ready=1, a single sample 8'h40 -> o_phase shows 0,1,2,3; o_valid is high for 4 consecutive cycles starting after edge k+1; o_fir_enable pulses once, on phase 3; the block then returns to IDLE.
REQ-036 Scenario 2: i_valid held high with samples 1,2,3 -> outputs run for 12 consecutive cycles with no bubble; o_ready is high only on cycles where phase is 3; o_fir_enable pulses 3 times.
REQ-037 Scenario 3: i_ready low for 3 cycles at phase 1 -> state is HOLD, o_data is stable, o_phase stays 1, and o_stall_count=3 (macro defined); when i_ready rises, the sequence resumes at phase 2.
REQ-038 Scenario 4: i_reset pulsed asynchronously at phase 2 -> all outputs go to 0 before the next edge; no o_fir_enable pulse occurs; after release, o_ready=1 and a new sample restarts at phase 0.
REQ-039 Scenario 5: i_fir_data driven to 8'h80 and 8'h7F -> o_data carries 8'h80 and 8'h7F bit-exact; i_valid asserted at phase 1 is not accepted (o_ready=0).
REQ-040 Scenario 6: build without FIR_SEQ_STALL_CNT_EN -> the port is absent, and Scenarios 1 to 4 produce identical output traces.

Source files
------------

// File: rtl/fir_phase_sequencer.sv
// Polyphase interpolation sequencer: holds one sample and steps the FIR coefficient bank per output.
// Optional stall counter output enabled by defining FIR_SEQ_STALL_CNT_EN.
module fir_phase_sequencer #(
   parameter int NB_DATA  = 8,
   parameter int N_PHASES = 4,
   parameter int NB_PHASE = 2
) (
   input  logic                       clock,
   input  logic                       i_reset,
   input  logic                       i_valid,
   input  logic signed [NB_DATA-1:0]  i_data,
   output logic                       o_ready,
   output logic signed [NB_DATA-1:0]  o_fir_data,
   output logic [NB_PHASE-1:0]        o_phase,
   output logic                       o_fir_enable,
   input  logic signed [NB_DATA-1:0]  i_fir_data,
   output logic signed [NB_DATA-1:0]  o_data,
   output logic                       o_valid,
   input  logic                       i_ready
`ifdef FIR_SEQ_STALL_CNT_EN
   ,
   output logic [15:0]                o_stall_count
`endif
);

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_HOLD} state_t;

   localparam logic [NB_PHASE-1:0] LAST_PHASE = NB_PHASE'(N_PHASES - 1);

   state_t                     state, state_next;
   logic [NB_PHASE-1:0]        phase, phase_next;
   logic signed [NB_DATA-1:0]  sample_p0, sample_next;
   logic signed [NB_DATA-1:0]  data_p1, data_next;
   logic                       vld_p1, vld_next;
   logic                       slot_free;
   logic                       last_phase;
   logic                       accept;

   always_ff @(posedge clock or posedge i_reset) begin
      if (i_reset) begin
         state     <= ST_IDLE;
         phase     <= '0;
         sample_p0 <= '0;
         data_p1   <= '0;
         vld_p1    <= 1'b0;
      end else begin
         state     <= state_next;
         phase     <= phase_next;
         sample_p0 <= sample_next;
         data_p1   <= data_next;
         vld_p1    <= vld_next;
      end
   end

   always_comb begin
      slot_free    = !vld_p1 || i_ready;
      last_phase   = (phase == LAST_PHASE);
      o_ready      = !i_reset && ((state == ST_IDLE) ||
                                  (state == ST_RUN && last_phase && slot_free));
      o_fir_enable = !i_reset && (state == ST_RUN) && last_phase && slot_free;
      accept       = i_valid && o_ready;

      state_next  = state;
      phase_next  = phase;
      sample_next = sample_p0;
      data_next   = data_p1;
      vld_next    = vld_p1;

      case (state)
         ST_IDLE: begin
            if (i_ready) vld_next = 1'b0;
         end
         ST_RUN: begin
            if (slot_free) begin
               data_next = i_fir_data;
               vld_next  = 1'b1;
               // Phase only wraps through a new accept; otherwise it parks on the last phase.
               if (last_phase) state_next = ST_IDLE;
               else            phase_next = phase + NB_PHASE'(1);
            end else begin
               state_next = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (i_ready) begin
               state_next = ST_RUN;
               vld_next   = 1'b0;
            end
         end
         default: state_next = ST_IDLE;
      endcase

      if (accept) begin
         sample_next = i_data;
         phase_next  = '0;
         state_next  = ST_RUN;
      end
   end

   assign o_fir_data = sample_p0;
   assign o_phase    = phase;
   assign o_data     = data_p1;
   assign o_valid    = vld_p1;

`ifdef FIR_SEQ_STALL_CNT_EN
   always_ff @(posedge clock or posedge i_reset) begin
      if (i_reset)
         o_stall_count <= '0;
      else if (state == ST_HOLD && o_stall_count != 16'hFFFF)
         o_stall_count <= o_stall_count + 16'd1;
   end
`endif

endmodule

// File: tb/tb_fir_phase_sequencer.sv
// Directed bench for fir_phase_sequencer; the FIR is a stub returning sample + 16*phase, or a forced value.
`define CHK(tag, obs, exp) chk(tag, 32'(obs), 32'(exp))

module tb_fir_phase_sequencer;

  logic       clock;
  logic       i_reset;
  logic       i_valid;
  logic [7:0] i_data;
  logic       o_ready;
  logic [7:0] o_fir_data;
  logic [1:0] o_phase;
  logic       o_fir_enable;
  logic [7:0] i_fir_data;
  logic [7:0] o_data;
  logic       o_valid;
  logic       i_ready;
`ifdef FIR_SEQ_STALL_CNT_EN
  logic [15:0] stall_count;
`endif

  logic       fir_force;
  logic [7:0] fir_val;
  int         n_assert;
  int         n_fail;

  fir_phase_sequencer #(.NB_DATA(8), .N_PHASES(4), .NB_PHASE(2)) dut (
    .clock        (clock),
    .i_reset      (i_reset),
    .i_valid      (i_valid),
    .i_data       (i_data),
    .o_ready      (o_ready),
    .o_fir_data   (o_fir_data),
    .o_phase      (o_phase),
    .o_fir_enable (o_fir_enable),
    .i_fir_data   (i_fir_data),
    .o_data       (o_data),
    .o_valid      (o_valid),
    .i_ready      (i_ready)
`ifdef FIR_SEQ_STALL_CNT_EN
    ,
    .o_stall_count(stall_count)
`endif
  );

  assign i_fir_data = fir_force ? fir_val : (o_fir_data + {2'b00, o_phase, 4'b0000});

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clock) begin
    if (i_reset === 1'b0 && o_fir_enable === 1'b1) begin
      n_assert++;
      if (o_phase !== 2'd3) begin
        n_fail++;
        $error("FAIL inv_enable_phase observed=%0h expected=3", o_phase);
      end
      n_assert++;
      if (o_ready !== 1'b1) begin
        n_fail++;
        $error("FAIL inv_enable_ready observed=%0h expected=1", o_ready);
      end
    end
    if (i_reset === 1'b1) begin
      n_assert++;
      if (o_fir_enable !== 1'b0) begin
        n_fail++;
        $error("FAIL inv_rst_enable observed=%0h expected=0", o_fir_enable);
      end
    end
  end

  initial begin
    n_assert  = 0;
    n_fail    = 0;
    i_reset   = 1'b0;
    i_valid   = 1'b0;
    i_data    = 8'h00;
    i_ready   = 1'b1;
    fir_force = 1'b0;
    fir_val   = 8'h00;
    #3 i_reset = 1'b1;

    // Reset state
    @(negedge clock); #1;
    `CHK("rst_ready", o_ready, 1'b0);
    `CHK("rst_valid", o_valid, 1'b0);
    `CHK("rst_phase", o_phase, 2'd0);
    `CHK("rst_fir_data", o_fir_data, 8'h00);
    `CHK("rst_data", o_data, 8'h00);
    `CHK("rst_enable", o_fir_enable, 1'b0);
`ifdef FIR_SEQ_STALL_CNT_EN
    `CHK("rst_stall", stall_count, 16'd0);
`endif
    @(negedge clock); i_reset = 1'b0; #1;
    `CHK("rel_ready", o_ready, 1'b1);

    // Scenario 1: single sample 8'h40
    @(negedge clock); i_valid = 1'b1; i_data = 8'h40; #1;
    `CHK("s1_ready_idle", o_ready, 1'b1);
    @(negedge clock); i_valid = 1'b0; #1;
    `CHK("s1_n0_valid", o_valid, 1'b0);
    `CHK("s1_n0_phase", o_phase, 2'd0);
    `CHK("s1_n0_fir_data", o_fir_data, 8'h40);
    `CHK("s1_n0_ready", o_ready, 1'b0);
    `CHK("s1_n0_enable", o_fir_enable, 1'b0);
    @(negedge clock); #1;
    `CHK("s1_n1_valid", o_valid, 1'b1);
    `CHK("s1_n1_data", o_data, 8'h40);
    `CHK("s1_n1_phase", o_phase, 2'd1);
    `CHK("s1_n1_enable", o_fir_enable, 1'b0);
    @(negedge clock); #1;
    `CHK("s1_n2_data", o_data, 8'h50);
    `CHK("s1_n2_phase", o_phase, 2'd2);
    `CHK("s1_n2_enable", o_fir_enable, 1'b0);
    @(negedge clock); #1;
    `CHK("s1_n3_data", o_data, 8'h60);
    `CHK("s1_n3_phase", o_phase, 2'd3);
    `CHK("s1_n3_enable", o_fir_enable, 1'b1);
    `CHK("s1_n3_ready", o_ready, 1'b1);
    @(negedge clock); #1;
    `CHK("s1_n4_valid", o_valid, 1'b1);
    `CHK("s1_n4_data", o_data, 8'h70);
    `CHK("s1_n4_enable", o_fir_enable, 1'b0);
    `CHK("s1_n4_ready", o_ready, 1'b1);
    @(negedge clock); #1;
    `CHK("s1_n5_valid", o_valid, 1'b0);

    // Scenario 2: back-to-back samples 1,2,3
    @(negedge clock); i_valid = 1'b1; i_data = 8'h01; #1;
    `CHK("s2_ready_idle", o_ready, 1'b1);
    for (int s = 1; s <= 3; s++) begin
      for (int p = 0; p < 4; p++) begin
        @(negedge clock);
        if (p == 3) begin
          i_valid = (s < 3);
          i_data  = 8'(s + 1);
        end
        #1;
        `CHK("s2_phase", o_phase, p);
        `CHK("s2_fir_data", o_fir_data, s);
        `CHK("s2_ready", o_ready, p == 3);
        `CHK("s2_enable", o_fir_enable, p == 3);
        `CHK("s2_valid", o_valid, !(s == 1 && p == 0));
        if (!(s == 1 && p == 0))
          `CHK("s2_data", o_data, (p == 0) ? (s - 1 + 48) : (s + 16 * (p - 1)));
      end
    end
    @(negedge clock); #1;
    `CHK("s2_tail_valid", o_valid, 1'b1);
    `CHK("s2_tail_data", o_data, 8'h33);
    `CHK("s2_tail_enable", o_fir_enable, 1'b0);
    @(negedge clock); #1;
    `CHK("s2_done_valid", o_valid, 1'b0);

    // Scenario 3: downstream stall at phase 1
    @(negedge clock); i_valid = 1'b1; i_data = 8'h20; #1;
    @(negedge clock); i_valid = 1'b0; #1;
    `CHK("s3_n0_phase", o_phase, 2'd0);
    @(negedge clock); i_ready = 1'b0; #1;
    `CHK("s3_n1_data", o_data, 8'h20);
    `CHK("s3_n1_phase", o_phase, 2'd1);
    `CHK("s3_n1_ready", o_ready, 1'b0);
    @(negedge clock); #1;
    `CHK("s3_n2_valid", o_valid, 1'b1);
    `CHK("s3_n2_data", o_data, 8'h20);
    `CHK("s3_n2_phase", o_phase, 2'd1);
    @(negedge clock); #1;
    `CHK("s3_n3_data", o_data, 8'h20);
    `CHK("s3_n3_phase", o_phase, 2'd1);
`ifdef FIR_SEQ_STALL_CNT_EN
    `CHK("s3_n3_stall", stall_count, 16'd1);
`endif
    @(negedge clock); i_ready = 1'b1; #1;
    `CHK("s3_n4_valid", o_valid, 1'b1);
    `CHK("s3_n4_data", o_data, 8'h20);
    `CHK("s3_n4_enable", o_fir_enable, 1'b0);
    `CHK("s3_n4_ready", o_ready, 1'b0);
`ifdef FIR_SEQ_STALL_CNT_EN
    `CHK("s3_n4_stall", stall_count, 16'd2);
`endif
    @(negedge clock); #1;
    `CHK("s3_n5_valid", o_valid, 1'b0);
    `CHK("s3_n5_phase", o_phase, 2'd1);
`ifdef FIR_SEQ_STALL_CNT_EN
    `CHK("s3_n5_stall", stall_count, 16'd3);
`endif
    @(negedge clock); #1;
    `CHK("s3_n6_data", o_data, 8'h30);
    `CHK("s3_n6_phase", o_phase, 2'd2);
    @(negedge clock); #1;
    `CHK("s3_n7_data", o_data, 8'h40);
    `CHK("s3_n7_enable", o_fir_enable, 1'b1);
    @(negedge clock); #1;
    `CHK("s3_n8_data", o_data, 8'h50);
    @(negedge clock); #1;
    `CHK("s3_n9_valid", o_valid, 1'b0);

    // Scenario 4: asynchronous reset at phase 2
    @(negedge clock); i_valid = 1'b1; i_data = 8'h11; #1;
    @(negedge clock); i_valid = 1'b0; #1;
    @(negedge clock); #1;
    `CHK("s4_n1_data", o_data, 8'h11);
    @(negedge clock); #1;
    `CHK("s4_n2_phase", o_phase, 2'd2);
    `CHK("s4_n2_data", o_data, 8'h21);
    #1 i_reset = 1'b1;
    #1;
    `CHK("s4_async_valid", o_valid, 1'b0);
    `CHK("s4_async_data", o_data, 8'h00);
    `CHK("s4_async_fir_data", o_fir_data, 8'h00);
    `CHK("s4_async_phase", o_phase, 2'd0);
    `CHK("s4_async_ready", o_ready, 1'b0);
    `CHK("s4_async_enable", o_fir_enable, 1'b0);
    @(negedge clock); #1;
    `CHK("s4_held_enable", o_fir_enable, 1'b0);
    `CHK("s4_held_phase", o_phase, 2'd0);
`ifdef FIR_SEQ_STALL_CNT_EN
    `CHK("s4_held_stall", stall_count, 16'd0);
`endif
    @(negedge clock); i_reset = 1'b0; i_valid = 1'b1; i_data = 8'h05; #1;
    `CHK("s4_rel_ready", o_ready, 1'b1);
    @(negedge clock); i_valid = 1'b0; #1;
    `CHK("s4_new_phase", o_phase, 2'd0);
    `CHK("s4_new_fir_data", o_fir_data, 8'h05);
    `CHK("s4_new_valid", o_valid, 1'b0);
    @(negedge clock); #1;
    `CHK("s4_new_data", o_data, 8'h05);
    `CHK("s4_new_phase1", o_phase, 2'd1);
    repeat (5) @(negedge clock);
    #1;
    `CHK("s4_idle_valid", o_valid, 1'b0);
    `CHK("s4_idle_ready", o_ready, 1'b1);

    // Scenario 5: extreme FIR values pass bit-exact; no accept mid-sequence
    @(negedge clock); fir_force = 1'b1; fir_val = 8'h80; i_valid = 1'b1; i_data = 8'h01; #1;
    @(negedge clock); i_valid = 1'b0; #1;
    `CHK("s5_n0_phase", o_phase, 2'd0);
    @(negedge clock); i_valid = 1'b1; i_data = 8'h55; fir_val = 8'h7F; #1;
    `CHK("s5_n1_data", o_data, 8'h80);
    `CHK("s5_n1_phase", o_phase, 2'd1);
    `CHK("s5_n1_ready", o_ready, 1'b0);
    @(negedge clock); i_valid = 1'b0; #1;
    `CHK("s5_n2_data", o_data, 8'h7F);
    `CHK("s5_n2_fir_data", o_fir_data, 8'h01);
    `CHK("s5_n2_phase", o_phase, 2'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
